mu0_control: RTL and testbench

//  Control unit for the MU0 processor. It sits directly upstream of mu0_datapath.
//  It consumes F (IR[15:12]) and the N and Z flags, and drives every datapath select, enable and ALU-mode line.
//  It also drives the memory Rd/Wr strobes and runs a FETCH/EXECUTE/HALT state machine.
//  A Mem_ready handshake stretches memory cycles. A saturating counter tracks retired instructions.

---
 rtl/mu0_control.sv | 144 ++++++++++++++
 tb/tb_mu0_control.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mu0_control.sv
// rtl/mu0_control.sv - MU0 control unit: FETCH/EXEC/HALT sequencer and datapath strobe decode
module mu0_control #(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [3:0]       F,
    input  logic             N,
    input  logic             Z,
    input  logic             Mem_ready,
    output logic             X_sel,
    output logic             Y_sel,
    output logic             Addr_sel,
    output logic             PC_En,
    output logic             IR_En,
    output logic             Acc_En,
    output logic [1:0]       M,
    output logic             Rd,
    output logic             Wr,
    output logic             Halted,
    output logic [CNT_W-1:0] Instr_count
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] EXEC  = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] ALU_Y    = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_INC  = 2'b10;
    localparam logic [1:0] ALU_SUB  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [1:0] state;
    logic [1:0] next_state;
    logic       retire;

    always_comb begin
        X_sel      = 1'b0;
        Y_sel      = 1'b0;
        Addr_sel   = 1'b0;
        PC_En      = 1'b0;
        IR_En      = 1'b0;
        Acc_En     = 1'b0;
        M          = ALU_Y;
        Rd         = 1'b0;
        Wr         = 1'b0;
        Halted     = 1'b0;
        next_state = state;

        case (state)
            FETCH: begin
                Rd    = 1'b1;
                X_sel = 1'b1;
                M     = ALU_INC;
                IR_En = Mem_ready;
                PC_En = Mem_ready;
                if (Mem_ready) begin
                    next_state = EXEC;
                end
            end

            EXEC: begin
                next_state = FETCH;
                case (F)
                    OP_LDA: begin
                        Addr_sel = 1'b1;
                        Rd       = 1'b1;
                        M        = ALU_Y;
                        Acc_En   = Mem_ready;
                        if (!Mem_ready) next_state = EXEC;
                    end
                    OP_STA: begin
                        Addr_sel = 1'b1;
                        Wr       = 1'b1;
                        if (!Mem_ready) next_state = EXEC;
                    end
                    OP_ADD, OP_SUB: begin
                        Addr_sel = 1'b1;
                        Rd       = 1'b1;
                        M        = (F == OP_ADD) ? ALU_ADD : ALU_SUB;
                        Acc_En   = Mem_ready;
                        if (!Mem_ready) next_state = EXEC;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        Y_sel = 1'b1;
                        M     = ALU_Y;
                        if (F == OP_JMP)      PC_En = 1'b1;
                        else if (F == OP_JGE) PC_En = ~N;
                        else                  PC_En = ~Z;
                    end
                    OP_STP: begin
                        next_state = HALT;
                    end
                    default: begin
                        next_state = FETCH;
                    end
                endcase
            end

            HALT: begin
                Halted = 1'b1;
            end

            default: begin
                next_state = FETCH;
            end
        endcase

        // Reset must not let a half-finished instruction touch memory or registers.
        if (Reset) begin
            PC_En  = 1'b0;
            IR_En  = 1'b0;
            Acc_En = 1'b0;
            Rd     = 1'b0;
            Wr     = 1'b0;
        end
    end

    assign retire = (state == EXEC) && (next_state != EXEC);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= FETCH;
            Instr_count <= '0;
        end else begin
            state <= next_state;
            if (retire && (Instr_count != CNT_MAX)) begin
                Instr_count <= Instr_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mu0_control.sv
// tb/tb_mu0_control.sv - bench for mu0_control with an MU0 datapath/memory model and a reference sequencer
module tb_mu0_control;

    logic        Clk = 1'b0;
    logic        Reset, Reset2;
    logic        Mem_ready;
    logic [3:0]  F;
    logic        N, Z;
    logic        X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, Rd, Wr, Halted;
    logic [1:0]  M;
    logic [15:0] Instr_count;

    logic        X_sel2, Y_sel2, Addr_sel2, PC_En2, IR_En2, Acc_En2, Rd2, Wr2, Halted2;
    logic [1:0]  M2;
    logic [1:0]  Instr_count2;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 Clk = ~Clk;

    mu0_control #(.CNT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .F(F), .N(N), .Z(Z), .Mem_ready(Mem_ready),
        .X_sel(X_sel), .Y_sel(Y_sel), .Addr_sel(Addr_sel), .PC_En(PC_En),
        .IR_En(IR_En), .Acc_En(Acc_En), .M(M), .Rd(Rd), .Wr(Wr),
        .Halted(Halted), .Instr_count(Instr_count)
    );

    mu0_control #(.CNT_W(2)) dut_nop (
        .Clk(Clk), .Reset(Reset2), .F(4'h8), .N(1'b0), .Z(1'b0), .Mem_ready(1'b1),
        .X_sel(X_sel2), .Y_sel(Y_sel2), .Addr_sel(Addr_sel2), .PC_En(PC_En2),
        .IR_En(IR_En2), .Acc_En(Acc_En2), .M(M2), .Rd(Rd2), .Wr(Wr2),
        .Halted(Halted2), .Instr_count(Instr_count2)
    );

    // MU0 datapath and memory, steered by the control outputs
    logic [15:0] mem [0:4095];
    logic [15:0] ir, acc, xv, yv, alu, din;
    logic [11:0] pc, addr;

    always_comb begin
        addr = Addr_sel ? ir[11:0] : pc;
        din  = mem[addr];
        xv   = X_sel ? {4'b0, pc} : acc;
        yv   = Y_sel ? ir : din;
        case (M)
            2'b00:   alu = yv;
            2'b01:   alu = xv + yv;
            2'b10:   alu = xv + 16'd1;
            default: alu = xv - yv;
        endcase
        F = ir[15:12];
        N = acc[15];
        Z = (acc == 16'd0);
    end

    always @(posedge Clk) begin
        if (Reset) begin
            pc  <= '0;
            ir  <= '0;
            acc <= '0;
        end else begin
            if (Wr && Mem_ready) mem[addr] <= xv;
            if (IR_En) ir  <= din;
            if (PC_En) pc  <= alu[11:0];
            if (Acc_En) acc <= alu;
        end
    end

    // Reference sequencer: phase 0 = fetch, 1 = execute, 2 = halted
    int          ref_phase [2];
    int          ref_cnt   [2];
    bit          ref_valid [2] = '{0, 0};
    int          cnt_limit [2] = '{65535, 3};
    logic [3:0]  in_f  [2];
    logic        in_n  [2], in_z [2], in_mr [2], in_rst [2];
    logic [10:0] obs   [2];
    int          obs_cnt [2];

    always_comb begin
        in_f[0] = F;     in_n[0] = N;    in_z[0] = Z;    in_mr[0] = Mem_ready; in_rst[0] = Reset;
        in_f[1] = 4'h8;  in_n[1] = 1'b0; in_z[1] = 1'b0; in_mr[1] = 1'b1;      in_rst[1] = Reset2;
        obs[0] = {X_sel, Y_sel, Addr_sel, PC_En, IR_En, Acc_En, M, Rd, Wr, Halted};
        obs[1] = {X_sel2, Y_sel2, Addr_sel2, PC_En2, IR_En2, Acc_En2, M2, Rd2, Wr2, Halted2};
        obs_cnt[0] = int'(Instr_count);
        obs_cnt[1] = int'(Instr_count2);
    end

    function automatic bit is_mem_op(logic [3:0] f);
        return f <= 4'h3;
    endfunction

    function automatic logic [10:0] expect_out(int ph, logic [3:0] f, logic n, logic z,
                                               logic mr, logic rst);
        logic xs, ys, as, pe, ie, ae, rd, wr, h;
        logic [1:0] m;
        {xs, ys, as, pe, ie, ae, rd, wr, h} = '0;
        m = 2'b00;
        if (ph == 0) begin
            xs = 1; m = 2'b10; rd = 1; ie = mr; pe = mr;
        end else if (ph == 1) begin
            if (is_mem_op(f)) begin
                as = 1;
                if (f == 4'h1) wr = 1;
                else begin
                    rd = 1;
                    ae = mr;
                    m  = (f == 4'h0) ? 2'b00 : (f == 4'h2) ? 2'b01 : 2'b11;
                end
            end else if (f >= 4'h4 && f <= 4'h6) begin
                ys = 1;
                pe = (f == 4'h4) || (f == 4'h5 && !n) || (f == 4'h6 && !z);
            end
        end else begin
            h = 1;
        end
        if (rst) {pe, ie, ae, rd, wr} = '0;
        return {xs, ys, as, pe, ie, ae, m, rd, wr, h};
    endfunction

    always @(posedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (in_rst[i]) begin
                ref_phase[i] <= 0;
                ref_cnt[i]   <= 0;
                ref_valid[i] <= 1;
            end else if (ref_phase[i] == 0) begin
                if (in_mr[i]) ref_phase[i] <= 1;
            end else if (ref_phase[i] == 1) begin
                if (!(is_mem_op(in_f[i]) && !in_mr[i])) begin
                    ref_phase[i] <= (in_f[i] == 4'h7) ? 2 : 0;
                    ref_cnt[i]   <= (ref_cnt[i] < cnt_limit[i]) ? ref_cnt[i] + 1 : ref_cnt[i];
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            if (ref_valid[i]) begin
                chk($sformatf("model_outputs[%0d]", i), int'(obs[i]),
                    int'(expect_out(ref_phase[i], in_f[i], in_n[i], in_z[i], in_mr[i], in_rst[i])));
                chk($sformatf("model_count[%0d]", i), obs_cnt[i], ref_cnt[i]);
            end
        end
    end

    task automatic clear_mem();
        for (int a = 0; a < 4096; a++) mem[a] = 16'h0000;
    endtask

    initial begin
        Reset = 1'b1; Reset2 = 1'b1; Mem_ready = 1'b1;
        clear_mem();
        mem[0] = 16'h0010; mem[1] = 16'h2011; mem[2] = 16'h1012; mem[3] = 16'h7000;
        mem[12'h010] = 16'd3; mem[12'h011] = 16'd4;
        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b0; Reset2 = 1'b0;

        // Program A: LDA/ADD/STA/STP, Mem_ready tied high
        for (int c = 0; c < 10; c++) begin
            @(negedge Clk);
            if (c == 0) begin
                chk("t1_rd", Rd, 1);       chk("t1_ir_en", IR_En, 1);
                chk("t1_pc_en", PC_En, 1); chk("t1_m", M, 2);
                chk("t1_x_sel", X_sel, 1); chk("t1_count", Instr_count, 0);
            end
            if (c == 1) chk("t6_nop_quiet", obs[1], 0);
            if (c == 7) chk("t2_not_yet_halted", Halted, 0);
            if (c == 8) begin
                chk("t2_halted", Halted, 1);
                chk("t2_count", Instr_count, 4);
            end
            if (c == 9) begin
                chk("t2_mem12", mem[12'h012], 7);
                chk("t2_still_halted", Halted, 1);
                chk("t6_count_sat", Instr_count2, 3);
            end
            @(posedge Clk); #1;
        end

        // Program B: conditional jumps, a stalled LDA, then reset during STA
        Reset = 1'b1;
        clear_mem();
        mem[0] = 16'h0020; mem[1] = 16'h5005; mem[2] = 16'h0021; mem[3] = 16'h5006;
        mem[4] = 16'h7000; mem[5] = 16'h7000; mem[6] = 16'h0022; mem[7] = 16'h6009;
        mem[8] = 16'h0023; mem[9] = 16'h1024;
        mem[12'h020] = 16'h8000; mem[12'h021] = 16'h0001;
        mem[12'h022] = 16'h0000; mem[12'h023] = 16'h0005;
        @(posedge Clk); #1;
        Reset = 1'b0;

        for (int c = 0; c < 20; c++) begin
            Mem_ready = !((c >= 13 && c <= 15) || c == 18);
            Reset     = (c == 18);
            @(negedge Clk);
            case (c)
                3:  chk("t3_jge_neg_pc_en", PC_En, 0);
                7:  begin
                        chk("t3_jge_pos_pc_en", PC_En, 1);
                        chk("t3_jge_y_sel", Y_sel, 1);
                        chk("t3_jge_m", M, 0);
                    end
                11: chk("t3_jne_zero_pc_en", PC_En, 0);
                13, 14, 15: begin
                        chk("t4_stall_rd", Rd, 1);
                        chk("t4_stall_acc_en", Acc_En, 0);
                        chk("t4_stall_addr_sel", Addr_sel, 1);
                    end
                16: chk("t4_acc_en", Acc_En, 1);
                17: chk("t4_next_fetch", IR_En, 1);
                18: begin
                        chk("t5_wr_gated", Wr, 0);
                        chk("t5_count_before", Instr_count, 7);
                    end
                19: begin
                        chk("t5_fetch_rd", Rd, 1);
                        chk("t5_fetch_x_sel", X_sel, 1);
                        chk("t5_count_cleared", Instr_count, 0);
                    end
                default: ;
            endcase
            @(posedge Clk); #1;
        end
        Reset = 1'b0;
        Mem_ready = 1'b1;
        @(negedge Clk);
        chk("t6_count_holds", Instr_count2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
